rx_fifo: RTL and testbench
==========================

# rx_fifo

Receive-side buffer directly downstream of the UART receiver. Accepts each byte the receiver flags with RDA, acknowledges it with a one-cycle clr_rda pulse, and stores it in an 8-deep FIFO. The processor drains it over the shared IOCS/IORW DATABUS interface, so back-to-back frames are not lost while software is slow to respond.

## Interface
- DEPTH, 8, FIFO entries; power of two, at least 2
- AW, 3, pointer width, log2(DEPTH)
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  asynchronous, active-low reset
- rx_data  in  8  byte from the receiver's data output; valid while rda=1
- rda  in  1  receiver data-available flag; level, held until cleared
- clr_rda  out  1  one-cycle acknowledge to the receiver
- IOCS  in  1  processor chip select
- IORW  in  1  1 = read, 0 = write
- IOADDR  in  2  register select: 00 = data, 01 = status/control
- DATABUS  inout  8  processor bus; driven only during a read, otherwise Z
- rx_ready  out  1  FIFO not empty
- overflow  out  1  sticky flag: a byte was dropped because the FIFO was full

## Operation
- Capture FSM states:
  - IDLE: if rda=1, push rx_data, or drop it and set overflow if full. Set clr_rda<=1 and go to ACK.
  - ACK: set clr_rda<=0 and go to WAIT_LOW.
  - WAIT_LOW: stay until rda=0, then go to IDLE.
- The FSM never captures the same RDA assertion twice.
- Storage: DEPTH×8 register array, wr_ptr and rd_ptr (AW bits, wrap modulo DEPTH), count (AW+1 bits).
  - full = (count==DEPTH); empty = (count==0).
- Read strobe: rs = IOCS & IORW & (IOADDR==00).
  - rs_q is rs registered.
  - Pop occurs on the edge where rs_q=1 and rs=0, i.e. at the end of the access.
  - Pop is ignored if empty.
- DATABUS while IOCS & IORW:
  - IOADDR 00: mem[rd_ptr], or 0x00 if empty.
  - IOADDR 01: status = {1'b0, count[3:0], overflow, full, ~empty}, for DEPTH=8.
  - IOADDR 1x: 0x00.
  - Otherwise DATABUS is high-Z.
- Write (IOCS & ~IORW & IOADDR==01) with DATABUS[2]=1 clears overflow. All other writes are ignored.
- Simultaneous push and pop in one cycle:
  - Both take effect and count is unchanged.
  - full is evaluated before the edge, so a push while full is dropped and sets overflow even if a pop happens in the same cycle.
- Overflow set and clear in the same cycle: set wins.
- rx_ready = ~empty, combinational from count.

## Timing
- Reset values:
  - wr_ptr, rd_ptr, count = 0
  - overflow = 0, clr_rda = 0, rx_ready = 0
  - FSM = IDLE, rs_q = 0
  - DATABUS = Z
- Memory contents are not reset.
- Capture latency:
  - rda sampled high at edge N: the byte is written and count increments at N.
  - clr_rda is high for exactly the cycle N to N+1.
  - rx_ready rises after edge N.
- Pop latency: rs falls, and at the next edge rd_ptr advances and count decrements.
- Minimum spacing between captures is 3 cycles (IDLE→ACK→WAIT_LOW→IDLE), well below one UART bit time.
- rst asserted mid-operation clears the FIFO immediately. A pending clr_rda is deasserted, and the receiver's RDA stays set until the next capture after release.
- DATABUS drive enable is purely combinational from IOCS/IORW: no bus contention one cycle after deselect.

## Test plan
- Reset: pulse rst low with IOCS=0, then release. Expect DATABUS=Z, rx_ready=0, clr_rda=0; a read of IOADDR 01 returns 0x00.
- Single byte:
  - Stimulus: rx_data=0xA5, rda=1 until clr_rda is seen, receiver drops rda 1 cycle later.
  - Expect clr_rda high for exactly 1 cycle and status 0x09.
  - Read IOADDR 00 (held 3 cycles): returns 0xA5 throughout the access.
  - After strobe release, status is 0x00.
- Full and overflow:
  - Push 0x01..0x08: status 0x43.
  - Push 0x09: clr_rda still pulses, status 0x47, overflow=1.
  - Eight reads return 0x01..0x08 in order.
  - Write 0x04 to IOADDR 01: overflow=0.
- Wrap-around: push and pop 5 bytes, then push 0x10..0x17. Reads return 0x10..0x17 in order; status goes 0x43 → 0x00.
- Simultaneous push and pop:
  - With 3 bytes stored, end a read on the same edge as an rda capture: count stays 3, and order is preserved.
  - With 8 stored, the same event drops the pushed byte and sets overflow.
- Reset mid-operation: with 4 stored and a read in progress, pulse rst. Expect status 0x00, DATABUS Z after IOCS drops, and the next byte captured normally into entry 0.

Source files
------------

// File: rtl/rx_fifo.sv
// ---------------------------------------------------------------------------
// rx_fifo
//
// Receive-side buffer between the UART receiver and the processor bus.
// Each byte the receiver flags with rda is acknowledged with a one-cycle
// clr_rda pulse and stored in a DEPTH-entry FIFO. The processor reads bytes
// and status over the shared IOCS/IORW/IOADDR/DATABUS interface.
//
// Ports:
//   clk      - system clock, all state changes on the rising edge
//   rst      - asynchronous active-low reset
//   rx_data  - byte from the receiver, valid while rda=1
//   rda      - receiver data-available level flag
//   clr_rda  - one-cycle acknowledge back to the receiver
//   IOCS     - processor chip select
//   IORW     - 1 = read, 0 = write
//   IOADDR   - 00 = data register, 01 = status/control, 1x = unused
//   DATABUS  - bidirectional processor bus, driven only during a read
//   rx_ready - FIFO holds at least one byte
//   overflow - sticky flag, a byte was dropped because the FIFO was full
// ---------------------------------------------------------------------------
module rx_fifo #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rda,
    output logic       clr_rda,
    input  logic       IOCS,
    input  logic       IORW,
    input  logic [1:0] IOADDR,
    inout  wire  [7:0] DATABUS,
    output logic       rx_ready,
    output logic       overflow
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ACK      = 2'd1;
    localparam logic [1:0] ST_WAIT_LOW = 2'd2;

    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   COUNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [1:0]    state;
    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          rs;
    logic          rs_q;
    logic          capture;
    logic          push;
    logic          pop;
    logic          ovf_clear;
    logic          bus_oe;
    logic [7:0]    bus_out;
    logic [3:0]    count_field;
    logic [7:0]    status;

    assign full     = (count == FULL_COUNT);
    assign empty    = (count == '0);
    assign rx_ready = ~empty;

    // A byte is taken only in IDLE, so a single rda assertion that is held
    // for several cycles is captured exactly once.
    assign capture = (state == ST_IDLE) & rda;
    assign push    = capture & ~full;

    // The pop is taken when the data-register read strobe falls, so the
    // processor sees a stable byte for the whole access.
    assign rs  = IOCS & IORW & (IOADDR == 2'b00);
    assign pop = rs_q & ~rs & ~empty;

    // The write data bit comes from the bus while the processor drives it.
    assign ovf_clear = IOCS & ~IORW & (IOADDR == 2'b01) & DATABUS[2];

    assign count_field = 4'(count);
    assign status      = {1'b0, count_field, overflow, full, ~empty};

    // Read mux for the processor side; an empty FIFO reads as zero rather
    // than exposing stale memory contents.
    always_comb begin
        bus_out = 8'h00;
        case (IOADDR)
            2'b00:   bus_out = empty ? 8'h00 : mem[rd_ptr];
            2'b01:   bus_out = status;
            default: bus_out = 8'h00;
        endcase
    end

    // Drive enable depends only on the select inputs so the bus is released
    // in the same cycle the processor deselects.
    assign bus_oe  = IOCS & IORW;
    assign DATABUS = bus_oe ? bus_out : 8'hzz;

    // Capture handshake: acknowledge for one cycle, then wait for the
    // receiver to drop rda before looking for the next byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            clr_rda <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (rda) begin
                        clr_rda <= 1'b1;
                        state   <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    clr_rda <= 1'b0;
                    state   <= ST_WAIT_LOW;
                end
                ST_WAIT_LOW: begin
                    if (!rda) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    clr_rda <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

    // Storage array carries no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    // Pointers and occupancy. A push and pop on the same edge leave the
    // count unchanged; full is judged before the edge, so a byte arriving
    // while full is dropped even if a pop frees a slot on that edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            rs_q   <= 1'b0;
        end else begin
            rs_q <= rs;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Sticky overflow; a drop on the same edge as a software clear wins.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (capture & full) begin
            overflow <= 1'b1;
        end else if (ovf_clear) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rx_fifo.sv
// ---------------------------------------------------------------------------
// tb_rx_fifo
//
// Self-checking bench for rx_fifo. A queue-based model of the FIFO and its
// sticky overflow flag predicts every byte and status value read over the
// bus. The bus has a weak pull-up, so a released bus reads as 0xFF.
// ---------------------------------------------------------------------------
module tb_rx_fifo;

    localparam int DEPTH = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rda = 1'b0;
    logic       clr_rda;
    logic       iocs = 1'b0;
    logic       iorw = 1'b0;
    logic [1:0] ioaddr = 2'b00;
    logic       rx_ready;
    logic       overflow;
    logic       tb_drive = 1'b0;
    logic [7:0] tb_wdata = 8'h00;
    tri1  [7:0] databus;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] model_q[$];
    logic       model_ovf = 1'b0;

    assign databus = tb_drive ? tb_wdata : 8'hzz;

    rx_fifo #(.DEPTH(DEPTH), .AW(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_data  (rx_data),
        .rda      (rda),
        .clr_rda  (clr_rda),
        .IOCS     (iocs),
        .IORW     (iorw),
        .IOADDR   (ioaddr),
        .DATABUS  (databus),
        .rx_ready (rx_ready),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    // Every comparison in the bench goes through here.
    task automatic check_output(input string tag, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t",
                     tag, actual, expected, $time);
        end
    endtask

    // Expected status byte built from the model occupancy.
    function automatic logic [7:0] model_status();
        logic [3:0] c;
        logic       f;
        logic       ne;
        c  = 4'(model_q.size());
        f  = (model_q.size() == DEPTH);
        ne = (model_q.size() != 0);
        return {1'b0, c, model_ovf, f, ne};
    endfunction

    function automatic logic [7:0] model_head();
        return (model_q.size() != 0) ? model_q[0] : 8'h00;
    endfunction

    task automatic model_push(input logic [7:0] b);
        if (model_q.size() == DEPTH) model_ovf = 1'b1;
        else model_q.push_back(b);
    endtask

    task automatic model_pop();
        if (model_q.size() != 0) void'(model_q.pop_front());
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Receiver side: raise rda, expect a one-cycle acknowledge, optionally
    // hold rda high longer to confirm it is not captured twice.
    task automatic send_byte(input logic [7:0] b, input int extra);
        rx_data = b;
        rda     = 1'b1;
        #1;
        check_output("clr_rda_before_capture", clr_rda, 1'b0);
        tick();
        model_push(b);
        check_output("clr_rda_pulse", clr_rda, 1'b1);
        check_output("rx_ready_after_capture", rx_ready, 1'b1);
        tick();
        check_output("clr_rda_one_cycle", clr_rda, 1'b0);
        for (int i = 0; i < extra; i++) begin
            tick();
            check_output("clr_rda_no_recapture", clr_rda, 1'b0);
        end
        rda = 1'b0;
        tick();
    endtask

    // Data register read held for 'hold' cycles, then released; the pop
    // lands on the edge after release.
    task automatic read_data(input int hold);
        logic [7:0] expv;
        expv   = model_head();
        iocs   = 1'b1;
        iorw   = 1'b1;
        ioaddr = 2'b00;
        #1;
        check_output("read_data", databus, expv);
        for (int i = 1; i < hold; i++) begin
            tick();
            check_output("read_data_stable", databus, expv);
        end
        tick();
        iocs = 1'b0;
        iorw = 1'b0;
        #1;
        check_output("bus_released", databus, 8'hFF);
        tick();
        model_pop();
    endtask

    task automatic read_status();
        iocs   = 1'b1;
        iorw   = 1'b1;
        ioaddr = 2'b01;
        #1;
        check_output("status", databus, model_status());
        tick();
        iocs   = 1'b0;
        iorw   = 1'b0;
        ioaddr = 2'b00;
        tick();
    endtask

    task automatic read_other(input logic [1:0] addr);
        iocs   = 1'b1;
        iorw   = 1'b1;
        ioaddr = addr;
        #1;
        check_output("read_unused_addr", databus, 8'h00);
        check_output("overflow_flag", overflow, model_ovf);
        check_output("rx_ready_flag", rx_ready, model_q.size() != 0);
        tick();
        iocs   = 1'b0;
        iorw   = 1'b0;
        ioaddr = 2'b00;
        tick();
    endtask

    task automatic write_reg(input logic [1:0] addr, input logic [7:0] data);
        iocs     = 1'b1;
        iorw     = 1'b0;
        ioaddr   = addr;
        tb_wdata = data;
        tb_drive = 1'b1;
        tick();
        if (addr == 2'b01 && data[2]) model_ovf = 1'b0;
        iocs     = 1'b0;
        tb_drive = 1'b0;
        ioaddr   = 2'b00;
        tick();
    endtask

    // End a data read on the same edge that a new byte is captured.
    task automatic push_pop_same_edge(input logic [7:0] b);
        logic was_full;
        iocs   = 1'b1;
        iorw   = 1'b1;
        ioaddr = 2'b00;
        #1;
        check_output("simul_read_data", databus, model_head());
        tick();
        iocs    = 1'b0;
        iorw    = 1'b0;
        rx_data = b;
        rda     = 1'b1;
        tick();
        was_full = (model_q.size() == DEPTH);
        model_pop();
        if (was_full) model_ovf = 1'b1;
        else model_q.push_back(b);
        check_output("simul_clr_rda", clr_rda, 1'b1);
        tick();
        check_output("simul_clr_rda_low", clr_rda, 1'b0);
        rda = 1'b0;
        tick();
    endtask

    task automatic drain();
        while (model_q.size() != 0) read_data(1);
    endtask

    // Directed scenarios followed by a randomized mix of bus and receiver
    // traffic, all predicted by the queue model.
    task automatic apply_stimulus();
        logic [7:0] b;
        int         r;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_bus_z", databus, 8'hFF);
        check_output("reset_rx_ready", rx_ready, 1'b0);
        check_output("reset_clr_rda", clr_rda, 1'b0);
        check_output("reset_overflow", overflow, 1'b0);
        rst = 1'b1;
        tick();
        read_status();

        // single byte
        send_byte(8'hA5, 0);
        read_status();
        read_data(3);
        read_status();

        // fill, overflow, drain, clear
        for (int i = 1; i <= 8; i++) send_byte(8'(i), 0);
        read_status();
        send_byte(8'h09, 0);
        read_status();
        check_output("overflow_set", overflow, 1'b1);
        for (int i = 0; i < 8; i++) read_data(1);
        write_reg(2'b01, 8'h04);
        check_output("overflow_cleared", overflow, 1'b0);
        read_status();

        // wrap-around
        for (int i = 0; i < 5; i++) begin
            send_byte(8'($urandom_range(0, 254)), 0);
            read_data(1);
        end
        for (int i = 0; i < 8; i++) send_byte(8'(8'h10 + i), 0);
        read_status();
        for (int i = 0; i < 8; i++) begin
            read_data($urandom_range(1, 3));
            read_status();
        end

        // push and pop on the same edge, partly full then full
        for (int i = 0; i < 3; i++) send_byte(8'($urandom_range(0, 254)), 0);
        push_pop_same_edge(8'h5C);
        read_status();
        drain();
        for (int i = 0; i < 8; i++) send_byte(8'($urandom_range(0, 254)), 0);
        push_pop_same_edge(8'hC5);
        read_status();
        check_output("simul_full_overflow", overflow, 1'b1);

        // drop and software clear on the same edge: the drop wins
        send_byte(8'h33, 0);
        write_reg(2'b01, 8'h04);
        read_status();
        iocs     = 1'b1;
        iorw     = 1'b0;
        ioaddr   = 2'b01;
        tb_wdata = 8'h04;
        tb_drive = 1'b1;
        rx_data  = 8'h44;
        rda      = 1'b1;
        tick();
        model_ovf = 1'b1;
        iocs      = 1'b0;
        tb_drive  = 1'b0;
        ioaddr    = 2'b00;
        tick();
        rda = 1'b0;
        tick();
        check_output("set_beats_clear", overflow, 1'b1);
        drain();
        read_status();

        // randomized traffic
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 9);
            b = 8'($urandom_range(0, 254));
            case (r)
                0, 1, 2, 3: send_byte(b, $urandom_range(0, 2));
                4, 5:       read_data($urandom_range(1, 3));
                6:          read_status();
                7:          write_reg(2'($urandom_range(0, 3)), 8'($urandom));
                8:          push_pop_same_edge(b);
                default:    read_other(2'($urandom_range(2, 3)));
            endcase
        end

        // reset mid-operation with a read in progress and clr_rda pending
        drain();
        for (int i = 0; i < 4; i++) send_byte(8'($urandom_range(0, 254)), 0);
        b       = 8'h6E;
        rx_data = b;
        rda     = 1'b1;
        iocs    = 1'b1;
        iorw    = 1'b1;
        ioaddr  = 2'b00;
        tick();
        check_output("pre_reset_clr_rda", clr_rda, 1'b1);
        rst = 1'b0;
        #1;
        check_output("midreset_clr_rda", clr_rda, 1'b0);
        check_output("midreset_rx_ready", rx_ready, 1'b0);
        check_output("midreset_overflow", overflow, 1'b0);
        check_output("midreset_read_empty", databus, 8'h00);
        ioaddr = 2'b01;
        #1;
        check_output("midreset_status", databus, 8'h00);
        rst = 1'b1;
        model_q.delete();
        model_ovf = 1'b0;
        #1;
        check_output("postreset_status", databus, model_status());
        iocs   = 1'b0;
        iorw   = 1'b0;
        ioaddr = 2'b00;
        #1;
        check_output("postreset_bus_z", databus, 8'hFF);
        tick();
        model_push(b);
        check_output("recapture_clr_rda", clr_rda, 1'b1);
        tick();
        check_output("recapture_clr_rda_low", clr_rda, 1'b0);
        rda = 1'b0;
        tick();
        read_status();
        read_data(2);
        read_status();
    endtask

    initial begin
        apply_stimulus();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
